// File: rtl/ram_arbiter_pkg.sv
// Shared types and helpers for the RAM arbiter: FSM state encoding,
// policy constants and the grant-index width function.
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Width of a port index; never below one bit so a 1-port build still elaborates.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ram_arbiter_pick.sv
// Combinational winner selection: lowest eligible index in fixed mode, or
// the first eligible index after last_grant (wrapping) in round-robin mode.
module ram_arbiter_pick
  import ram_arbiter_pkg::*;
#(
  parameter int PORTS = 3,
  parameter int IW    = idx_width(PORTS)
) (
  input  logic [PORTS-1:0] eligible,
  input  logic [IW-1:0]    last_grant,
  input  logic             rr,
  output logic [IW-1:0]    winner,
  output logic             valid
);

  logic [IW-1:0] cand;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    cand   = '0;
    for (int i = 0; i < PORTS; i++) begin
      cand = rr ? IW'((int'(last_grant) + 1 + i) % PORTS) : IW'(i);
      if (!valid && eligible[cand]) begin
        winner = cand;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one registered-read single-port RAM among PORTS requesters with a
// clocked req/ready handshake; one access takes IDLE, ACCESS, RESP plus a turnaround.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int PORTS  = 3,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int RR     = 0
) (
  input  logic                     ram_clk,
  input  logic                     rst,
  input  logic [PORTS-1:0]         req,
  input  logic [PORTS-1:0]         we,
  input  logic [PORTS*ADDR_W-1:0]  addr,
  input  logic [PORTS*DATA_W-1:0]  wdata,
  output logic [PORTS-1:0]         ready,
  output logic [PORTS*DATA_W-1:0]  rdata,
  output logic                     ram_write_enable,
  output logic [ADDR_W-1:0]        ram_address,
  output logic [DATA_W-1:0]        ram_data_in,
  input  logic [DATA_W-1:0]        ram_data_out,
  output logic                     busy
);

  localparam int IW = idx_width(PORTS);

  // Handshake: a requester raises req with addr/we/wdata stable and keeps them
  // until ready pulses for one cycle; that pulse cycle masks the port and no
  // grant is issued in it, so a still-high req afterwards is a new transaction.

  state_t          state, state_next;
  logic [PORTS-1:0] eligible;
  logic [IW-1:0]    grant, last_grant, winner;
  logic             win_valid, do_grant;

  assign eligible = req & ~ready;
  assign do_grant = (state == IDLE) && win_valid && (ready == '0);
  assign busy     = (state != IDLE);

  ram_arbiter_pick #(
    .PORTS (PORTS),
    .IW    (IW)
  ) u_pick (
    .eligible   (eligible),
    .last_grant (last_grant),
    .rr         (RR == ARB_RR),
    .winner     (winner),
    .valid      (win_valid)
  );

  always_ff @(posedge ram_clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (do_grant) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ram_clk) begin
    if (rst) begin
      grant            <= '0;
      last_grant       <= IW'(PORTS - 1);
      ram_write_enable <= 1'b0;
      ram_address      <= '0;
      ram_data_in      <= '0;
      ready            <= '0;
      rdata            <= '0;
    end else begin
      ready <= '0;
      if (do_grant) begin
        grant            <= winner;
        last_grant       <= winner;
        ram_write_enable <= we[winner];
        ram_address      <= addr[winner*ADDR_W +: ADDR_W];
        ram_data_in      <= wdata[winner*DATA_W +: DATA_W];
      end
      // Write enable is still the granted we[] here, so it tells read from write.
      if (state == RESP) begin
        ready[grant] <= 1'b1;
        if (!ram_write_enable) rdata[grant*DATA_W +: DATA_W] <= ram_data_out;
        ram_write_enable <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a fixed-priority and a round-robin instance share
// stimulus, each with its own RAM and a transaction-level reference model.
module tb_ram_arbiter;

  localparam int P  = 3;
  localparam int AW = 16;
  localparam int DW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [P-1:0]    req, we;
  logic [P*AW-1:0] addr;
  logic [P*DW-1:0] wdata;

  logic [P-1:0]    ready_o    [2];
  logic [P*DW-1:0] rdata_o    [2];
  logic            ram_we_o   [2];
  logic [AW-1:0]   ram_addr_o [2];
  logic [DW-1:0]   ram_din_o  [2];
  logic            busy_o     [2];

  for (genvar k = 0; k < 2; k++) begin : g_inst
    logic [DW-1:0] mem [65536];
    logic [DW-1:0] dout;

    ram_arbiter #(
      .PORTS(P), .ADDR_W(AW), .DATA_W(DW), .RR(k)
    ) u_dut (
      .ram_clk          (clk),
      .rst              (rst),
      .req              (req),
      .we               (we),
      .addr             (addr),
      .wdata            (wdata),
      .ready            (ready_o[k]),
      .rdata            (rdata_o[k]),
      .ram_write_enable (ram_we_o[k]),
      .ram_address      (ram_addr_o[k]),
      .ram_data_in      (ram_din_o[k]),
      .ram_data_out     (dout),
      .busy             (busy_o[k])
    );

    initial begin
      for (int i = 0; i < 65536; i++) mem[i] = '0;
      mem[16'h0010] = 8'hA5;
    end

    always @(posedge clk) begin
      if (ram_we_o[k]) mem[ram_addr_o[k]] <= ram_din_o[k];
      dout <= mem[ram_addr_o[k]];
    end
  end

  // ---------------- reference model ----------------
  // Transaction view: a grant completes 2 edges later; the next grant may not
  // come before 2 edges after completion.
  logic [P-1:0]  m_ready   [2];
  logic [DW-1:0] m_rdata   [2][P];
  logic          m_we      [2];
  logic [AW-1:0] m_addr    [2];
  logic [DW-1:0] m_din     [2];
  logic [DW-1:0] m_rd_val  [2];
  logic [DW-1:0] sh        [2][65536];
  bit            m_inflight[2];
  bit            m_is_wr   [2];
  int            m_due     [2];
  int            m_next_ok [2];
  int            m_g       [2];
  int            m_last    [2];
  int            edge_n = 0;
  bit            m_valid = 1'b0;
  int            w, c;

  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 65536; i++) sh[k][i] = '0;
      sh[k][16'h0010] = 8'hA5;
    end
  end

  always @(posedge clk) begin
    edge_n++;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_inflight[k] = 1'b0;
        m_next_ok[k]  = 0;
        m_ready[k]    = '0;
        for (int p = 0; p < P; p++) m_rdata[k][p] = '0;
        m_we[k]       = 1'b0;
        m_addr[k]     = '0;
        m_din[k]      = '0;
        m_last[k]     = P - 1;
      end else begin
        m_ready[k] = '0;
        if (m_inflight[k]) begin
          if (edge_n == m_due[k]) begin
            m_ready[k][m_g[k]] = 1'b1;
            if (!m_is_wr[k]) m_rdata[k][m_g[k]] = m_rd_val[k];
            m_inflight[k] = 1'b0;
            m_we[k]       = 1'b0;
            m_next_ok[k]  = edge_n + 2;
          end
        end else if (edge_n >= m_next_ok[k]) begin
          w = -1;
          for (int i = 0; i < P; i++) begin
            c = (k == 1) ? (m_last[k] + 1 + i) % P : i;
            if (w < 0 && req[c]) w = c;
          end
          if (w >= 0) begin
            m_g[k]        = w;
            m_last[k]     = w;
            m_inflight[k] = 1'b1;
            m_due[k]      = edge_n + 2;
            m_is_wr[k]    = we[w];
            m_we[k]       = we[w];
            m_addr[k]     = addr[w*AW +: AW];
            m_din[k]      = wdata[w*DW +: DW];
            if (we[w]) sh[k][m_addr[k]] = m_din[k];
            else       m_rd_val[k] = sh[k][m_addr[k]];
          end
        end
      end
    end
    m_valid = 1'b1;
  end

  // ---------------- scoreboard ----------------
  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    logic [P*DW-1:0] e;
    if (m_valid) begin
      for (int k = 0; k < 2; k++) begin
        for (int p = 0; p < P; p++) e[p*DW +: DW] = m_rdata[k][p];
        check($sformatf("i%0d ready", k), ready_o[k], m_ready[k]);
        check($sformatf("i%0d rdata", k), rdata_o[k], e);
        check($sformatf("i%0d busy", k), busy_o[k], m_inflight[k]);
        check($sformatf("i%0d ram_we", k), ram_we_o[k], m_we[k]);
        check($sformatf("i%0d ram_addr", k), ram_addr_o[k], m_addr[k]);
        check($sformatf("i%0d ram_din", k), ram_din_o[k], m_din[k]);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    model_check();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_port(input int p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    we[p]            = w;
    addr[p*AW +: AW]  = a;
    wdata[p*DW +: DW] = d;
  endtask

  // Ticks until ready[p] of instance k is seen; n = ticks taken, -1 on timeout.
  task automatic wait_ready(input int k, input int p, input int limit, output int n);
    bit found;
    found = 1'b0;
    n = 0;
    while (!found && n < limit) begin
      tick();
      n++;
      if (ready_o[k][p]) found = 1'b1;
    end
    if (!found) n = -1;
  endtask

  task automatic check_reset_values(input string tag);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s i%0d ready", tag, k), ready_o[k], 0);
      check($sformatf("%s i%0d rdata", tag, k), rdata_o[k], 0);
      check($sformatf("%s i%0d busy", tag, k), busy_o[k], 0);
      check($sformatf("%s i%0d ram_we", tag, k), ram_we_o[k], 0);
      check($sformatf("%s i%0d ram_addr", tag, k), ram_addr_o[k], 0);
      check($sformatf("%s i%0d ram_din", tag, k), ram_din_o[k], 0);
    end
  endtask

  // ---------------- directed sequence ----------------
  int n, cnt;
  int t [P];
  int seq_p[$];
  int seq_t[$];
  int pulse_t[$];

  initial begin
    rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
    idle(2);
    check_reset_values("reset");
    rst = 1'b0;
    idle(2);

    // Single read of preloaded location by port 1.
    set_port(1, 1'b0, 16'h0010, 8'h00);
    req = 3'b010;
    wait_ready(0, 1, 10, n);
    check("read latency", n, 3);
    check("read rdata1", rdata_o[0][1*DW +: DW], 8'hA5);
    check("read other ready", ready_o[0] & 3'b101, 0);
    req = '0;
    tick();
    check("read pulse width", ready_o[0][1], 0);

    // Port 2 writes, then port 0 reads it back.
    set_port(2, 1'b1, 16'h0100, 8'h3C);
    req = 3'b100;
    wait_ready(0, 2, 10, n);
    check("write latency", n, 3);
    check("write keeps rdata2", rdata_o[0][2*DW +: DW], 8'h00);
    req = '0;
    tick();
    set_port(0, 1'b0, 16'h0100, 8'h00);
    req = 3'b001;
    wait_ready(0, 0, 10, n);
    check("readback latency", n, 3);
    check("readback rdata0", rdata_o[0][0*DW +: DW], 8'h3C);
    req = '0;
    idle(2);

    // Fixed priority: three simultaneous requesters, each drops when served.
    set_port(0, 1'b0, 16'h0010, 8'h00);
    set_port(1, 1'b1, 16'h0200, 8'h11);
    set_port(2, 1'b0, 16'h0100, 8'h00);
    for (int p = 0; p < P; p++) t[p] = -1;
    req = 3'b111;
    for (int i = 1; i <= 20; i++) begin
      tick();
      for (int p = 0; p < P; p++)
        if (ready_o[0][p] && t[p] < 0) begin
          t[p] = i;
          req[p] = 1'b0;
        end
    end
    check("fixed t0", t[0], 3);
    check("fixed t1", t[1], 7);
    check("fixed t2", t[2], 11);
    check("fixed rdata2", rdata_o[0][2*DW +: DW], 8'h3C);
    req = '0;

    // Round-robin: ports 0 and 2 request continuously after a reset.
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    set_port(0, 1'b0, 16'h0010, 8'h00);
    set_port(2, 1'b0, 16'h0100, 8'h00);
    cnt = 0;
    req = 3'b101;
    for (int i = 1; i <= 20; i++) begin
      tick();
      for (int p = 0; p < P; p++)
        if (ready_o[1][p]) begin
          seq_p.push_back(p);
          seq_t.push_back(i);
        end
      if (ready_o[0][2]) cnt++;
    end
    check("rr grant count", seq_p.size(), 5);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rr order %0d", i), (seq_p.size() > i) ? seq_p[i] : -1, (i % 2 == 0) ? 0 : 2);
      check($sformatf("rr spacing %0d", i), (seq_t.size() > i + 1) ? seq_t[i+1] - seq_t[i] : -1, 4);
    end
    check("fixed starves port2", cnt, 0);
    req = '0;
    idle(4);

    // Mask rule: port 1 holds req across its pulse, drops after one more grant.
    set_port(1, 1'b0, 16'h0010, 8'h00);
    req = 3'b010;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (ready_o[0][1]) pulse_t.push_back(i);
      if (i == 4) check("mask cycle ready", ready_o[0][1], 0);
      if (i == 5) req = '0;
    end
    check("mask pulse count", pulse_t.size(), 2);
    check("mask pulse 1", (pulse_t.size() > 0) ? pulse_t[0] : -1, 3);
    check("mask pulse 2", (pulse_t.size() > 1) ? pulse_t[1] : -1, 7);
    idle(2);

    // Reset while a read is in ACCESS.
    set_port(1, 1'b0, 16'h0010, 8'h00);
    req = 3'b010;
    tick();
    check("granted busy", busy_o[0], 1);
    rst = 1'b1;
    tick();
    check_reset_values("mid reset");
    rst = 1'b0;
    req = '0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ready_o[0] != '0) cnt++;
    end
    check("no ready after abort", cnt, 0);
    req = 3'b010;
    wait_ready(0, 1, 10, n);
    check("post reset latency", n, 3);
    check("post reset rdata1", rdata_o[0][1*DW +: DW], 8'hA5);
    req = '0;
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Parametrised synchronous arbiter that shares one single-port RAM (registered read, one-cycle data latency) among PORTS requesters. It is the successor to the fixed three-way RAM prioritiser between the pipeline stages and `ram`. It adds:
- configurable port count and address/data widths;
- a selectable fixed-priority or round-robin policy;
- a fully clocked req/ready handshake with defined reset behaviour.

It sits between the fetch/load/store stages and the `ram` instance.

## Interface
Parameters:
- PORTS, 3, number of requesters (2..8); port 0 is highest priority in fixed mode.
- ADDR_W, 16, RAM address width.
- DATA_W, 8, RAM data width.
- RR, 0, 0 = fixed priority (lowest index wins), 1 = round-robin.

Ports:
- ram_clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req  in  PORTS  per-port request level.
- we  in  PORTS  per-port write enable, valid while req high.
- addr  in  PORTS*ADDR_W  per-port address, packed, port i at [i*ADDR_W +: ADDR_W].
- wdata  in  PORTS*DATA_W  per-port write data, packed.
- ready  out  PORTS  one-cycle completion pulse.
- rdata  out  PORTS*DATA_W  per-port read data, valid with ready.
- ram_write_enable  out  1  to RAM.
- ram_address  out  ADDR_W  to RAM.
- ram_data_in  out  DATA_W  to RAM.
- ram_data_out  in  DATA_W  from RAM, valid one cycle after RAM samples a read.
- busy  out  1  high while an access is in flight (state != IDLE).

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: with eligible = req & ~ready non-zero, pick winner g, latch g, drive ram_address = addr[g], ram_write_enable = we[g], ram_data_in = wdata[g]. Go to ACCESS.
- ACCESS: RAM samples on this edge. Go to RESP.
- RESP: on edge:
  - read: rdata[g] <= ram_data_out.
  - write: rdata[g] unchanged.
  - ready[g] <= 1; ram_write_enable <= 0; go to IDLE.
- ready is a single-cycle pulse. In that cycle req[g] is masked, so a still-high req is not re-granted from stale state. req[g] high in the following cycle is a new transaction.
- Requester holds addr/we/wdata stable from req rise until its ready pulse. Dropping req mid-transaction does not cancel the access; ready still pulses.
- Fixed mode: winner = lowest set index of eligible.
- RR mode: search starts at last_grant+1, wrapping modulo PORTS. last_grant updates on each grant.
- Non-requesting ports: ready and rdata untouched.

## Timing
- req seen at edge E0 (IDLE) → RAM signals valid after E0 → RAM samples at E1 → ready/rdata valid after E2, high until E3.
- Request-to-ready latency: 3 edges.
- Throughput: one access per 4 cycles under continuous contention (IDLE, ACCESS, RESP, mask cycle).
- Reset values:
  - ready = 0, rdata = 0, busy = 0;
  - ram_write_enable = 0, ram_address = 0, ram_data_in = 0;
  - state IDLE, last_grant = PORTS-1, so port 0 is first in RR.
- rst mid-access: in-flight access is abandoned, no ready pulse, ram_write_enable drops on the reset edge. A write already sampled in ACCESS is not rolled back. Requesters must re-request.
- Simultaneous requests in IDLE: exactly one grant; others wait with req held.
- Single requester asserting continuously: served every 4 cycles in both modes.

## Structure
- Package ram_arbiter_pkg:
  - state enum (IDLE/ACCESS/RESP);
  - mode constants ARB_FIXED = 0, ARB_RR = 1;
  - function computing clog2(PORTS) for the grant index width.
- Sub-module ram_arbiter_pick: combinational. Inputs are eligible vector, last_grant and RR. Outputs are winner index and valid. It is kept separate so the policy can be unit-tested.
- Top holds the FSM, the grant register and the output registers.

## Test plan
- Read: ram preloaded with mem[0x0010] = 0xA5; port 1 req, we = 0, addr = 0x0010 → ready[1] pulses once, 3 edges after req sample, with rdata[1] = 0xA5; other ready bits stay 0.
- Write then read: port 2 writes 0x3C to 0x0100, then port 0 reads 0x0100 → port 0 receives 0x3C; rdata[2] unchanged by the write.
- Fixed priority: ports 0, 1, 2 request in the same cycle and hold req until served → ready order 0, 1, 2, spaced 4 cycles apart.
- Round-robin (RR = 1): ports 0 and 2 request continuously → grants alternate 0, 2, 0, 2; port 0 is never served twice in a row.
- Mask rule: port 1 holds req high across its ready pulse → exactly one additional transaction; no duplicate ready in the mask cycle.
- Reset in ACCESS: assert rst one cycle after a read grant → no ready pulse; all outputs equal reset values; next request is served normally with 3-edge latency.
